// File: rtl/data_memory.sv
// Word-organised data memory with byte/half/word access, sign/zero extension
// on loads, alignment and range checking, and a fixed request-to-response
// latency set by LATENCY.
module data_memory #(
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  count;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_address;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] op_address;
    logic [31:0] op_wdata;
    logic [IDX_W-1:0] op_index;
    logic        op_error;
    logic [3:0]  wr_mask;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the access happens on the accept edge itself, so the live
    // request fields are used; otherwise the captured copy is used.
    assign enter_resp  = (LATENCY == 1) ? accept : ((state == WAIT) && (count == 3'd0));
    assign op_write    = (LATENCY == 1) ? req_write    : cap_write;
    assign op_size     = (LATENCY == 1) ? req_size     : cap_size;
    assign op_unsigned = (LATENCY == 1) ? req_unsigned : cap_unsigned;
    assign op_address  = (LATENCY == 1) ? req_address  : cap_address;
    assign op_wdata    = (LATENCY == 1) ? req_wdata    : cap_wdata;
    assign op_index    = op_address[IDX_W+1:2];

    // Error decode, store lane mask/data and load extraction for the current operation
    always_comb begin
        op_error = 1'b0;
        if (op_size == 2'b11)                                 op_error = 1'b1;
        if ((op_size == 2'b01) && op_address[0])              op_error = 1'b1;
        if ((op_size == 2'b10) && (op_address[1:0] != 2'b00)) op_error = 1'b1;
        if ({2'b00, op_address[31:2]} >= 32'(DEPTH))          op_error = 1'b1;

        case (op_size)
            2'b00: begin
                wr_mask = 4'b0001 << op_address[1:0];
                wr_word = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wr_mask = op_address[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{op_wdata[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_word = op_wdata;
            end
        endcase

        rd_word   = mem[op_index];
        rd_shift  = rd_word >> {op_address[1:0], 3'b000};
        load_data = rd_word;
        case (op_size)
            2'b00: load_data = op_unsigned ? {24'b0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: load_data = op_unsigned ? {16'b0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // Store: lane-masked write on the edge entering RESP; memory is never reset
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && op_write && !op_error) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask[k]) mem[op_index][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    // Control FSM, request capture and registered response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write    <= req_write;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_address  <= req_address;
                        cap_wdata    <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 3'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (count == 3'd0) state <= RESP;
                    else               count <= count - 3'd1;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_error <= op_error;
                resp_rdata <= (op_error || op_write) ? 32'd0 : load_data;
            end
        end
    end

endmodule
